// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one registered AND/OR unit (X=A&B, Y=B|C) among NUM_REQ requesters.
// One transaction in flight, fixed OP_LAT execute latency; define LOGIC_ARB_STATS_EN to add txn_count.
module logic_op_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int OP_LAT  = 2,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*WIDTH-1:0] req_c,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_x,
  output logic [WIDTH-1:0]         rsp_y,
  output logic                     busy
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [15:0]              txn_count
`endif
);

  localparam int CW = (OP_LAT > 1) ? $clog2(OP_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   id_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             rsp_vld_q;

  logic             gnt_vld;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   idx;
  logic [WIDTH-1:0] sel_a, sel_b, sel_c;

  // Walk from the farthest candidate back to rr_ptr so the nearest valid one wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
        sel_c = req_c[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && gnt_vld) req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      rsp_id_q  <= '0;
      rsp_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            a_q      <= sel_a;
            b_q      <= sel_b;
            c_q      <= sel_c;
            id_q     <= gnt_id;
            rr_ptr_q <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
            cnt_q    <= CW'(OP_LAT - 1);
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            x_q       <= a_q & b_q;
            y_q       <= b_q | c_q;
            rsp_id_q  <= id_q;
            rsp_vld_q <= 1'b1;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_vld_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_vld_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_x     = x_q;
  assign rsp_y     = y_q;
  assign busy      = (state_q != IDLE);

`ifdef LOGIC_ARB_STATS_EN
  logic [15:0] txn_q;

  // Saturates rather than wrapping so a long run never looks like a fresh one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_q <= '0;
    end else if (state_q == RESP && rsp_ready && txn_q != 16'hFFFF) begin
      txn_q <= txn_q + 16'd1;
    end
  end

  assign txn_count = txn_q;
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Randomized bench for logic_op_arbiter against a cycle-count transaction model.
module tb_logic_op_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int L   = 2;
  localparam int IDW = 2;
  localparam int SW  = $clog2(N * W);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b, req_c;
  logic           rsp_valid, rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_x, rsp_y;
  logic           busy;
`ifdef LOGIC_ARB_STATS_EN
  logic [15:0]    txn_count;
`endif

  logic_op_arbiter #(.NUM_REQ(N), .WIDTH(W), .OP_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .busy(busy)
`ifdef LOGIC_ARB_STATS_EN
    , .txn_count(txn_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: one outstanding transaction, response due L edges after its accept.
  int       m_rr, m_age, m_id, m_txn;
  bit       m_busy;
  logic [W-1:0] m_x, m_y;
  int       obs_hs;
  int       gq[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (m_busy) return -1;
    for (int k = 0; k < N; k++) begin
      int ix;
      ix = (m_rr + k) % N;
      if (req_valid[IDW'(ix)]) return ix;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] opnd(input logic [N*W-1:0] v, input int g);
    return v[SW'(g * W) +: W];
  endfunction

  task automatic model_reset();
    m_rr = 0; m_busy = 0; m_age = 0; m_txn = 0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    int g;
    bit due, hs;
    logic [N-1:0] er;
    #1;
    g   = model_grant();
    er  = (g >= 0) ? (N'(1) << g) : '0;
    due = m_busy && (m_age >= L);
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, due);
    chk("busy", busy, m_busy);
    if (due) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_x", rsp_x, m_x);
      chk("rsp_y", rsp_y, m_y);
    end
`ifdef LOGIC_ARB_STATS_EN
    chk("txn_count", txn_count, m_txn);
`endif
    for (int i = 0; i < N; i++) if (req_ready[IDW'(i)]) gq.push_back(i);
    if (rsp_valid && rsp_ready) obs_hs++;
    hs = due && rsp_ready;
    @(posedge clk);
    if (g >= 0) begin
      m_busy = 1; m_age = 0; m_id = g;
      m_x = opnd(req_a, g) & opnd(req_b, g);
      m_y = opnd(req_b, g) | opnd(req_c, g);
      m_rr = (g + 1) % N;
    end else if (hs) begin
      m_busy = 0;
      if (m_txn < 65535) m_txn++;
    end else if (m_busy) begin
      m_age++;
    end
    @(negedge clk);
  endtask

  task automatic rand_ops();
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    req_c = {$urandom, $urandom};
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int s = 0; s < 20 && m_busy; s++) step();
    chk("drain_idle", m_busy, 1'b0);
  endtask

  task automatic run_until_grants(input int n);
    for (int s = 0; s < 20 * n && gq.size() < n; s++) step();
    chk("grant_count", gq.size(), n);
  endtask

  task automatic run_txns(input int n);
    int start;
    start = obs_hs;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    for (int s = 0; s < 10 * n && (obs_hs - start) < n; s++) begin
      rand_ops();
      step();
    end
    chk("txn_handshakes", obs_hs - start, n);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs0;
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    rand_ops();
    model_reset();
    obs_hs = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_x", rsp_x, 0);
    chk("rst_rsp_y", rsp_y, 0);
    rst = 1'b0;
    req_valid = '0;

    // Single request from requester 2.
    req_valid = 4'b0100;
    req_a = '0; req_b = '0; req_c = '0;
    req_a[16 +: 8] = 8'hF0; req_b[16 +: 8] = 8'h3C; req_c[16 +: 8] = 8'h81;
    gq.delete();
    step();
    chk("single_grant", (gq.size() == 1) ? gq[0] : -1, 2);
    req_valid = '0;
    step();
    step();
    #1;
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 2);
    chk("single_x", rsp_x, 8'h30);
    chk("single_y", rsp_y, 8'hBD);
    step();
    #1;
    chk("single_busy_low", busy, 0);

    // Wrap: lone requester 3, then 0 and 3 competing.
    gq.delete();
    req_valid = 4'b1000;
    rand_ops();
    run_until_grants(1);
    req_valid = 4'b1001;
    run_until_grants(3);
    chk("wrap_g0", gq[0], 3);
    chk("wrap_g1", gq[1], 0);
    chk("wrap_g2", gq[2], 3);
    drain();

    // Round-robin over requesters 0,1,3.
    gq.delete();
    req_valid = 4'b1011;
    rand_ops();
    run_until_grants(6);
    for (int i = 0; i < 6; i++) begin
      int ex[6] = '{0, 1, 3, 0, 1, 3};
      chk("rr_order", gq[i], ex[i]);
    end
    drain();

    // Backpressure with every requester pending.
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    rand_ops();
    for (int s = 0; s < 10 && !(m_busy && m_age >= L); s++) step();
    req_valid = 4'b1111;
    gq.delete();
    hs0 = obs_hs;
    repeat (5) step();
    chk("bp_no_grant", gq.size(), 0);
    rsp_ready = 1'b1;
    step();
    chk("bp_one_hs", obs_hs - hs0, 1);
    drain();

    // Async reset in the middle of EXEC.
    req_valid = 4'b0100;
    rand_ops();
    step();
    req_valid = '0;
    #2 rst = 1'b1;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req_ready", req_ready, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) step();
    chk("arst_no_stale", obs_hs - hs0, 1);
    gq.delete();
    req_valid = 4'b1010;
    step();
    chk("arst_grant", (gq.size() == 1) ? gq[0] : -1, 1);
    drain();

    // Random traffic.
    for (int s = 0; s < 400; s++) begin
      req_valid = N'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      step();
    end
    drain();

`ifdef LOGIC_ARB_STATS_EN
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run_txns(3);
    #1;
    chk("stats_three", txn_count, 3);
    @(negedge clk);
    force dut.txn_q = 16'hFFFE;
    #1 release dut.txn_q;
    m_txn = 65534;
    @(negedge clk);
    run_txns(3);
    #1;
    chk("stats_sat", txn_count, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares one registered AND/OR logic unit between NUM_REQ requesters.
- The unit computes X = A & B and Y = B | C, with a programmable fixed latency.
- Round-robin arbitration, one transaction in flight, valid/ready on both request and response sides.
- Response is tagged with the requester index; the block sits between the requester front-ends and the shared logic datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- OP_LAT, 2, execute latency in cycles (>=1), models the shared unit's propagation delay.
- IDW, $clog2(NUM_REQ), requester-ID width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  input  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B, same packing.
- req_c  input  NUM_REQ*WIDTH  operand C, same packing.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  IDW  index of requester that owns the result.
- rsp_x  output  WIDTH  A & B.
- rsp_y  output  WIDTH  B | C.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0, cnt=0, rsp_valid=0, rsp_id=0, rsp_x=0, rsp_y=0, operand regs=0, busy=0. req_ready is 0 while rst is high.
- FSM states:
  - IDLE: if any req_valid, grant g = first valid index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. req_ready[g]=1 combinationally; all other req_ready bits are 0. On that clock edge: capture req_a/b/c[g] and id=g, set rr_ptr=(g+1) mod NUM_REQ, cnt=OP_LAT-1, go to EXEC. If no req_valid, stay in IDLE and leave rr_ptr unchanged.
  - EXEC: req_ready=0. If cnt==0: register rsp_x=A&B, rsp_y=B|C, rsp_id=id, set rsp_valid=1, go to RESP. Otherwise cnt decrements.
  - RESP: rsp_valid=1. rsp_x, rsp_y and rsp_id are held stable until rsp_valid&rsp_ready. On that edge: rsp_valid=0, go to IDLE.
- Latency: with the request accepted at edge T, rsp_valid is first high after edge T+OP_LAT.
- No new grant in the cycle the response handshake occurs. Minimum spacing between accepts is OP_LAT+2 cycles.
- A requester dropping req_valid while not granted is legal. req_valid/data only need to be stable in the accept cycle.
- Results are in-order and never lost or duplicated.
- rsp_ready held high in RESP: handshake completes in the first RESP cycle.
- rsp_ready asserted outside RESP is ignored.
- Reset during EXEC/RESP: in-flight transaction is discarded, no response is emitted, and rr_ptr returns to 0.
- rr_ptr wrap: after a grant to NUM_REQ-1, the pointer goes to 0.

Optional Feature:
- Macro LOGIC_ARB_STATS_EN.
- When defined: adds output port txn_count [15:0]. It is reset to 0 and increments on every response handshake, saturating at 16'hFFFF (no wrap).
- When undefined: port and counter are absent, and all other behaviour is identical.

Test Plan:
- Single request: req 2 valid, A=8'hF0, B=8'h3C, C=8'h81; rsp_ready=1 -> req_ready[2] high for 1 cycle; rsp_valid 2 cycles after accept with rsp_id=2, rsp_x=8'h30, rsp_y=8'hBD; busy low again the next cycle.
- Round-robin: reqs 0,1,3 held valid continuously, rsp_ready=1 -> grant order 0,1,3,0,1,3; each response id matches its operands.
- Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_valid, rsp_id, rsp_x and rsp_y stay constant, no req_ready pulses; after rsp_ready=1, exactly one handshake occurs.
- Wrap: only req 3 valid, then reqs 0 and 3 valid -> next grant is 0 (rr_ptr wrapped), then 3.
- Async reset mid-EXEC: assert rst between clock edges -> rsp_valid=0 and busy=0 immediately; no stale response after release; the next grant starts at rr_ptr=0.
- With LOGIC_ARB_STATS_EN: 3 completed transactions -> txn_count=3. Force the counter to 16'hFFFE and complete 3 more -> txn_count=16'hFFFF.
